change_dispenser: RTL and testbench

// Coin-output side of the vending datapath: takes a change amount in cents and ejects

---
 rtl/change_dispenser.sv | 231 +++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays change greedily as quarters, dimes, nickels,
// one coin at a time, tracking the stock of each coin tube.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   change request handshake (ready only in IDLE)
//   req_amount        change to pay, cents
//   refill_valid/coin add one coin: 00 nickel, 01 dime, 10 quarter
//   eject_q/d/n       coin eject strobes, at most one high
//   busy, done        busy outside IDLE, done pulses at end of payout
//   shortfall         unpaid remainder, updated with done
//   q/d/n_count       tube stock
module change_dispenser #(
  parameter int AMT_W      = 9,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 10,
  parameter int PULSE_CYC  = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill_valid,
  input  logic [1:0]       refill_coin,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [CNT_W-1:0] q_count,
  output logic [CNT_W-1:0] d_count,
  output logic [CNT_W-1:0] n_count
);

  localparam int TMAX =
    (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW =
    (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] P_LD =
    TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] G_LD =
    TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  localparam logic [CNT_W-1:0] C_INIT =
    CNT_W'(INIT_COUNT);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  localparam logic [AMT_W-1:0] V_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [AMT_W-1:0] r_rem;
  logic [AMT_W-1:0] r_short;
  logic [TW-1:0]    r_tmr;
  logic             r_done;
  logic             r_busy;
  logic             r_ready;
  logic             r_ej_q;
  logic             r_ej_d;
  logic             r_ej_n;
  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] r_d;
  logic [CNT_W-1:0] r_n;

  logic             w_sel;
  logic             w_can_q;
  logic             w_can_d;
  logic             w_can_n;
  logic             w_pick_q;
  logic             w_pick_d;
  logic             w_pick_n;
  logic             w_pick;
  logic [AMT_W-1:0] w_val;
  logic             w_ref_q;
  logic             w_ref_d;
  logic             w_ref_n;

  assign w_sel   = (r_state == S_SELECT);
  assign w_can_q = (r_rem >= V_Q) && (r_q != '0);
  assign w_can_d = (r_rem >= V_D) && (r_d != '0);
  assign w_can_n = (r_rem >= V_N) && (r_n != '0);

  // Largest coin first; no backtracking.
  assign w_pick_q = w_sel && w_can_q;
  assign w_pick_d = w_sel && !w_can_q && w_can_d;
  assign w_pick_n = w_sel && !w_can_q && !w_can_d
                    && w_can_n;
  assign w_pick   = w_pick_q | w_pick_d | w_pick_n;

  always_comb begin
    w_val = '0;
    unique case (1'b1)
      w_pick_q: w_val = V_Q;
      w_pick_d: w_val = V_D;
      w_pick_n: w_val = V_N;
      default:  w_val = '0;
    endcase
  end

  assign w_ref_q = refill_valid
                   && (refill_coin == 2'b10);
  assign w_ref_d = refill_valid
                   && (refill_coin == 2'b01);
  assign w_ref_n = refill_valid
                   && (refill_coin == 2'b00);

  // A refill and a payout of the same tube in one
  // cycle cancel out.
  function automatic logic [CNT_W-1:0] f_next(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec && (c != C_MAX))
      n = c + 1'b1;
    else if (dec && !inc)
      n = c - 1'b1;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= C_INIT;
      r_d <= C_INIT;
      r_n <= C_INIT;
    end else begin
      r_q <= f_next(r_q, w_ref_q, w_pick_q);
      r_d <= f_next(r_d, w_ref_d, w_pick_d);
      r_n <= f_next(r_n, w_ref_n, w_pick_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_short <= '0;
      r_tmr   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_ej_q  <= 1'b0;
      r_ej_d  <= 1'b0;
      r_ej_n  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_rem   <= req_amount;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_pick) begin
            r_rem   <= r_rem - w_val;
            r_ej_q  <= w_pick_q;
            r_ej_d  <= w_pick_d;
            r_ej_n  <= w_pick_n;
            r_tmr   <= P_LD;
            r_state <= S_EJECT;
          end else begin
            r_short <= r_rem;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_EJECT: begin
          if (r_tmr == '0) begin
            r_ej_q <= 1'b0;
            r_ej_d <= 1'b0;
            r_ej_n <= 1'b0;
            if (GAP_CYC == 0) begin
              r_state <= S_SELECT;
            end else begin
              r_tmr   <= G_LD;
              r_state <= S_GAP;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_GAP: begin
          if (r_tmr == '0)
            r_state <= S_SELECT;
          else
            r_tmr <= r_tmr - 1'b1;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign shortfall = r_short;
  assign eject_q   = r_ej_q;
  assign eject_d   = r_ej_d;
  assign eject_n   = r_ej_n;
  assign q_count   = r_q;
  assign d_count   = r_d;
  assign n_count   = r_n;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser.
// Greedy payout reference model with random amounts and refills.
module tb_change_dispenser;

  localparam int AMT_W = 9;
  localparam int CNT_W = 8;
  localparam int INIT  = 10;
  localparam int PULSE = 2;
  localparam int GAP   = 1;
  localparam int STEP  = 1 + PULSE + GAP;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             refill_valid = 1'b0;
  logic [1:0]       refill_coin = 2'b00;
  logic             eject_q;
  logic             eject_d;
  logic             eject_n;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] d_count;
  logic [CNT_W-1:0] n_count;

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W),
    .INIT_COUNT(INIT),
    .PULSE_CYC(PULSE), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid),
    .req_amount(req_amount),
    .req_ready(req_ready),
    .refill_valid(refill_valid),
    .refill_coin(refill_coin),
    .eject_q(eject_q), .eject_d(eject_d),
    .eject_n(eject_n),
    .busy(busy), .done(done),
    .shortfall(shortfall),
    .q_count(q_count), .d_count(d_count),
    .n_count(n_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int nq; int nd; int nn; int sf; int acc;
    int eq; int ed; int en;
  } exp_t;

  exp_t sb[$];
  exp_t tmp;
  int mq = INIT;
  int md = INIT;
  int mn = INIT;
  int k = 0;
  int w = 0;
  logic [2:0] s;

  task automatic chk(input string name,
                     input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Greedy payout as plain arithmetic on the
  // model stock.
  task automatic model(input int amt,
                       output exp_t e);
    int r;
    r = amt;
    e.nq = (r / 25 < mq) ? r / 25 : mq;
    r = r - 25 * e.nq;
    mq = mq - e.nq;
    e.nd = (r / 10 < md) ? r / 10 : md;
    r = r - 10 * e.nd;
    md = md - e.nd;
    e.nn = (r / 5 < mn) ? r / 5 : mn;
    r = r - 5 * e.nn;
    mn = mn - e.nn;
    e.sf = r;
    e.eq = mq;
    e.ed = md;
    e.en = mn;
    e.acc = 0;
  endtask

  task automatic on_coin();
    exp_t e;
    logic [2:0] es;
    if (sb.size() == 0) begin
      chk("stray_strobe", int'(s), 0);
      return;
    end
    e = sb[0];
    if (k < e.nq) es = 3'b100;
    else if (k < e.nq + e.nd) es = 3'b010;
    else if (k < e.nq + e.nd + e.nn) es = 3'b001;
    else es = 3'b000;
    chk($sformatf("coin%0d_type", k),
        int'(s), int'(es));
    chk($sformatf("coin%0d_time", k),
        cyc - e.acc, 2 + k * STEP);
    k++;
  endtask

  task automatic on_done();
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      chk("stray_done", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = e.nq + e.nd + e.nn;
    chk("coin_total", k, n);
    chk("shortfall", int'(shortfall), e.sf);
    chk("done_time", cyc - e.acc, 2 + n * STEP);
    chk("q_count", int'(q_count), e.eq);
    chk("d_count", int'(d_count), e.ed);
    chk("n_count", int'(n_count), e.en);
    k = 0;
  endtask

  // Monitor: strobe order/timing, pulse width,
  // and payout results on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0;
      w = 0;
    end else begin
      s = {eject_q, eject_d, eject_n};
      if ($countones(s) > 1)
        chk("onehot", $countones(s), 1);
      if (s != 3'b000) begin
        if (w == 0) on_coin();
        w++;
      end else if (w != 0) begin
        chk("pulse_width", w, PULSE);
        w = 0;
      end
      if (done) on_done();
    end
  end

  task automatic do_req(input int amt);
    int t;
    exp_t e;
    t = 0;
    while (!req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("ready_timeout", t, 0);
      return;
    end
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    model(amt, e);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("ready_after_accept", int'(req_ready), 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready)
           && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      chk("idle_timeout", t, 0);
      sb.delete();
    end
  endtask

  task automatic refill(input int c);
    refill_valid = 1'b1;
    refill_coin  = 2'(c);
    @(negedge clk);
    refill_valid = 1'b0;
    case (c)
      0: mn = sat(mn + 1);
      1: md = sat(md + 1);
      2: mq = sat(mq + 1);
      default: ;
    endcase
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_eject", int'({eject_q, eject_d,
                           eject_n}), 0);
    chk("rst_short", int'(shortfall), 0);
    chk("rst_q", int'(q_count), INIT);
    chk("rst_d", int'(d_count), INIT);
    chk("rst_n", int'(n_count), INIT);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(40);
    wait_idle();
    do_req(0);
    wait_idle();
    do_req(37);
    wait_idle();

    // request held while busy must be ignored
    do_req(40);
    req_valid  = 1'b1;
    req_amount = AMT_W'(5);
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);

    // dime refill in the SELECT cycle that
    // takes a dime
    do_req(10);
    refill_valid = 1'b1;
    refill_coin  = 2'b01;
    @(negedge clk);
    refill_valid = 1'b0;
    md++;
    tmp = sb.pop_back();
    tmp.ed++;
    sb.push_back(tmp);
    wait_idle();
    chk("d_same_cycle", int'(d_count), md);

    // drain all tubes, then pay with none
    do_req(511);
    wait_idle();
    chk("drained_q", int'(q_count), 0);
    chk("drained_d", int'(d_count), 0);
    chk("drained_n", int'(n_count), 0);
    do_req(65);
    wait_idle();
    refill(3);
    chk("ign_refill_q", int'(q_count), 0);
    chk("ign_refill_d", int'(d_count), 0);
    chk("ign_refill_n", int'(n_count), 0);

    // no backtracking: 30c with Q1 D3 N0
    refill(2);
    repeat (3) refill(1);
    do_req(30);
    wait_idle();

    repeat (260) refill(2);
    chk("q_saturate", int'(q_count), CMAX);

    // reset in the middle of the first strobe
    do_req(40);
    @(negedge clk);
    chk("pre_reset_ej_q", int'(eject_q), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ej_q", int'(eject_q), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_q", int'(q_count), INIT);
    chk("mid_rst_d", int'(d_count), INIT);
    chk("mid_rst_n", int'(n_count), INIT);
    sb.delete();
    mq = INIT;
    md = INIT;
    mn = INIT;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      int nr;
      nr = $urandom_range(0, 4);
      for (int j = 0; j < nr; j++)
        refill($urandom_range(0, 3));
      do_req($urandom_range(0, 300));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
